// File: rtl/stage_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : stage_sequencer
//  Description : Parametrised stage flow controller for the AES datapath.
//                Drives NUM_STAGES one-hot enables in ascending index order,
//                advancing when the active stage raises its ready. Stages can
//                be skipped per run through a mask sampled at Start. Includes
//                Start/Abort control, optional automatic restart, a per-stage
//                watchdog with sticky Error, and Done/Busy status.
//
//  Parameters  : NUM_STAGES   number of sequenced stages (2..16)
//                IDX_W        width of CurStage, 2**IDX_W >= NUM_STAGES
//                TO_W         width of watchdog counter / TimeoutLimit
//                AUTO_RESTART 1 = loop back to the first enabled stage after
//                             Done without waiting for Start
//
//  Ports       : Clk          system clock, rising edge
//                Rst          asynchronous active-high reset
//                Start        begin a run (accepted only in IDLE)
//                Abort        synchronous return to IDLE, clears Error
//                SkipMask     bit i = 1 skips stage i (sampled at Start)
//                TimeoutLimit cycles allowed per stage, 0 = no watchdog
//                StageRy      ready/done from each stage
//                StageEn      one-hot enable of the active stage
//                CurStage     index of the active stage, 0 when none
//                Busy         high while a stage is being run
//                Done         one-cycle pulse at run completion
//                Error        sticky watchdog error
//                RunCycles    RUN-cycle count of the last completed run
//
//  Build macro : STAGE_SEQ_CYCLE_COUNT_EN -- when defined, builds the 32-bit
//                run-cycle counter behind RunCycles; otherwise RunCycles = 0.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module stage_sequencer #(
    parameter int NUM_STAGES   = 6,
    parameter int IDX_W        = 4,
    parameter int TO_W         = 16,
    parameter int AUTO_RESTART = 0
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Start,
    input  logic                  Abort,
    input  logic [NUM_STAGES-1:0] SkipMask,
    input  logic [TO_W-1:0]       TimeoutLimit,
    input  logic [NUM_STAGES-1:0] StageRy,
    output logic [NUM_STAGES-1:0] StageEn,
    output logic [IDX_W-1:0]      CurStage,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error,
    output logic [31:0]           RunCycles
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam logic [TO_W-1:0] c_WdogMax = '1;

    state_t                  r_state;
    state_t                  w_nextState;
    logic [NUM_STAGES-1:0]   r_mask;
    logic [TO_W-1:0]         r_wdog;
    logic [TO_W-1:0]         w_wdogNext;
    logic [TO_W-1:0]         w_wdogInc;
    logic                    w_wdogHit;
    logic [IDX_W-1:0]        w_nextIdx;
    logic [NUM_STAGES-1:0]   w_nextOneHot;
    logic                    w_loadMask;
    logic                    w_stageReady;
    logic [IDX_W:0]          w_startHit;
    logic [IDX_W:0]          w_succHit;
    logic [IDX_W:0]          w_restartHit;

    // Lowest unskipped stage index >= lo. Result MSB flags "found".
    function automatic logic [IDX_W:0] findStage(
        input logic [NUM_STAGES-1:0] mask,
        input int                    lo
    );
        logic [IDX_W:0] res;
        res = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if ((i >= lo) && !mask[i]) begin
                res = {1'b1, IDX_W'(i)};
            end
        end
        return res;
    endfunction

    assign w_startHit   = findStage(SkipMask, 0);
    assign w_succHit    = findStage(r_mask, int'(CurStage) + 1);
    assign w_restartHit = findStage(r_mask, 0);

    // StageEn is one-hot on the active stage in RUN and zero elsewhere, so
    // masking with it picks the active ready and ignores all other stages.
    assign w_stageReady = |(StageRy & StageEn);

    assign w_wdogInc = (r_wdog == c_WdogMax) ? r_wdog : (r_wdog + TO_W'(1));
    assign w_wdogHit = (TimeoutLimit != '0) && (w_wdogInc >= TimeoutLimit);

    assign w_nextOneHot = {{(NUM_STAGES-1){1'b0}}, 1'b1} << w_nextIdx;

    always_comb begin
        w_nextState = r_state;
        w_nextIdx   = CurStage;
        w_wdogNext  = r_wdog;
        w_loadMask  = 1'b0;
        if (Abort) begin
            w_nextState = ST_IDLE;
            w_wdogNext  = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (Start) begin
                        w_loadMask = 1'b1;
                        w_wdogNext = '0;
                        if (w_startHit[IDX_W]) begin
                            w_nextState = ST_RUN;
                            w_nextIdx   = w_startHit[IDX_W-1:0];
                        end else begin
                            w_nextState = ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    // Ready takes precedence over a watchdog hit in the same cycle.
                    if (w_stageReady) begin
                        w_wdogNext = '0;
                        if (w_succHit[IDX_W]) begin
                            w_nextState = ST_RUN;
                            w_nextIdx   = w_succHit[IDX_W-1:0];
                        end else begin
                            w_nextState = ST_DONE;
                        end
                    end else if (w_wdogHit) begin
                        w_nextState = ST_ERR;
                    end else begin
                        w_wdogNext = w_wdogInc;
                    end
                end
                ST_DONE: begin
                    // With every stage masked there is nothing to restart into,
                    // so an auto-restart build falls back to IDLE in that case.
                    if ((AUTO_RESTART != 0) && w_restartHit[IDX_W]) begin
                        w_nextState = ST_RUN;
                        w_nextIdx   = w_restartHit[IDX_W-1:0];
                        w_wdogNext  = '0;
                    end else begin
                        w_nextState = ST_IDLE;
                    end
                end
                ST_ERR: begin
                    w_nextState = ST_ERR;
                end
                default: begin
                    w_nextState = ST_IDLE;
                end
            endcase
        end
    end

    // State and all status outputs are registered together from the next
    // state, so outputs never depend combinationally on inputs.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state  <= ST_IDLE;
            r_mask   <= '0;
            r_wdog   <= '0;
            StageEn  <= '0;
            CurStage <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Error    <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_wdog  <= w_wdogNext;
            if (w_loadMask) begin
                r_mask <= SkipMask;
            end
            StageEn  <= (w_nextState == ST_RUN) ? w_nextOneHot : '0;
            CurStage <= (w_nextState == ST_RUN) ? w_nextIdx : '0;
            Busy     <= (w_nextState == ST_RUN);
            Done     <= (w_nextState == ST_DONE);
            Error    <= (w_nextState == ST_ERR);
        end
    end

`ifdef STAGE_SEQ_CYCLE_COUNT_EN
    logic [31:0] r_cycCnt;
    logic [31:0] w_cycInc;
    logic        w_clrCnt;

    assign w_cycInc = (r_cycCnt == 32'hFFFF_FFFF) ? r_cycCnt : (r_cycCnt + 32'd1);
    // Entering RUN from outside RUN means a fresh run (Start or auto-restart).
    assign w_clrCnt = (w_nextState == ST_RUN) && (r_state != ST_RUN);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_cycCnt  <= '0;
            RunCycles <= '0;
        end else begin
            if (w_clrCnt) begin
                r_cycCnt <= '0;
            end else if (r_state == ST_RUN) begin
                r_cycCnt <= w_cycInc;
            end
            // Capture includes the final RUN cycle; an all-skipped run has none.
            if (w_nextState == ST_DONE) begin
                RunCycles <= (r_state == ST_RUN) ? w_cycInc : '0;
            end
        end
    end
`else
    assign RunCycles = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stage_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stage_sequencer
//  Description : Directed self-checking bench for stage_sequencer. One DUT
//                with default parameters and one with AUTO_RESTART = 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_sequencer;

`ifdef STAGE_SEQ_CYCLE_COUNT_EN
    localparam bit c_CycEn = 1'b1;
`else
    localparam bit c_CycEn = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Start, Abort;
    logic [5:0]  SkipMask, StageRy, StageEn;
    logic [15:0] TimeoutLimit;
    logic [3:0]  CurStage;
    logic        Busy, Done, Error;
    logic [31:0] RunCycles;

    logic        StartAr, AbortAr;
    logic [5:0]  SkipAr, RyAr, EnAr;
    logic [15:0] LimitAr;
    logic [3:0]  CurAr;
    logic        BusyAr, DoneAr, ErrAr;
    logic [31:0] RunCycAr;

    int checkCnt = 0;
    int errCnt   = 0;

    always #5 Clk = ~Clk;

    stage_sequencer #(.NUM_STAGES(6), .IDX_W(4), .TO_W(16), .AUTO_RESTART(0)) u_dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Abort(Abort), .SkipMask(SkipMask),
        .TimeoutLimit(TimeoutLimit), .StageRy(StageRy), .StageEn(StageEn),
        .CurStage(CurStage), .Busy(Busy), .Done(Done), .Error(Error),
        .RunCycles(RunCycles)
    );

    stage_sequencer #(.NUM_STAGES(6), .IDX_W(4), .TO_W(16), .AUTO_RESTART(1)) u_dutAr (
        .Clk(Clk), .Rst(Rst), .Start(StartAr), .Abort(AbortAr), .SkipMask(SkipAr),
        .TimeoutLimit(LimitAr), .StageRy(RyAr), .StageEn(EnAr),
        .CurStage(CurAr), .Busy(BusyAr), .Done(DoneAr), .Error(ErrAr),
        .RunCycles(RunCycAr)
    );

    task automatic checkValue(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checkCnt++;
        if (act !== exp) begin
            errCnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [31:0] expCyc(input int n);
        return c_CycEn ? 32'(n) : 32'd0;
    endfunction

    initial begin
        int seqSkip[4];
        int seqAr[4];
        seqSkip = '{0, 1, 4, 5};
        seqAr   = '{0, 1, 4, 5};

        Rst = 1'b1; Start = 1'b0; Abort = 1'b0; SkipMask = '0; StageRy = '0; TimeoutLimit = '0;
        StartAr = 1'b0; AbortAr = 1'b0; SkipAr = '0; RyAr = '0; LimitAr = '0;
        tick; tick;
        checkValue("rst en", StageEn, 0);
        checkValue("rst cur", CurStage, 0);
        checkValue("rst busy", Busy, 0);
        checkValue("rst done", Done, 0);
        checkValue("rst err", Error, 0);
        checkValue("rst cyc", RunCycles, 0);
        Rst = 1'b0;
        tick;

        // Full run: each stage ready on its 4th enabled cycle.
        Start = 1'b1;
        tick;
        Start = 1'b0;
        for (int s = 0; s < 6; s++) begin
            for (int c = 0; c < 4; c++) begin
                checkValue($sformatf("full en s%0d c%0d", s, c), StageEn, 32'(1 << s));
                checkValue($sformatf("full cur s%0d", s), CurStage, 32'(s));
                checkValue("full busy", Busy, 1);
                checkValue("full done", Done, 0);
                StageRy = (c == 3) ? 6'(1 << s) : 6'd0;
                tick;
            end
        end
        StageRy = '0;
        checkValue("full done pulse", Done, 1);
        checkValue("full done busy", Busy, 0);
        checkValue("full done en", StageEn, 0);
        checkValue("full runcycles", RunCycles, expCyc(24));
        tick;
        checkValue("full done end", Done, 0);
        checkValue("full idle busy", Busy, 0);

        // Skip stages 2 and 3, stray ready on stage 3 while stage 1 runs.
        SkipMask = 6'b001100;
        Start = 1'b1;
        tick;
        Start = 1'b0;
        SkipMask = '0;
        for (int i = 0; i < 4; i++) begin
            checkValue($sformatf("skip en a%0d", i), StageEn, 32'(1 << seqSkip[i]));
            checkValue($sformatf("skip cur a%0d", i), CurStage, 32'(seqSkip[i]));
            StageRy = (seqSkip[i] == 1) ? 6'b001000 : 6'd0;
            tick;
            checkValue($sformatf("skip en b%0d", i), StageEn, 32'(1 << seqSkip[i]));
            StageRy = 6'(1 << seqSkip[i]);
            tick;
        end
        StageRy = '0;
        checkValue("skip done", Done, 1);
        checkValue("skip runcycles", RunCycles, expCyc(8));
        tick;

        // Ready held high: one cycle per stage.
        StageRy = 6'h3F;
        Start = 1'b1;
        tick;
        Start = 1'b0;
        for (int s = 0; s < 6; s++) begin
            checkValue($sformatf("rdy en s%0d", s), StageEn, 32'(1 << s));
            tick;
        end
        checkValue("rdy done", Done, 1);
        checkValue("rdy runcycles", RunCycles, expCyc(6));
        StageRy = '0;
        tick;

        // Watchdog: stage 2 never ready, limit 5.
        TimeoutLimit = 16'd5;
        StageRy = 6'b000011;
        Start = 1'b1;
        tick;
        Start = 1'b0;
        tick;
        tick;
        for (int c = 0; c < 5; c++) begin
            checkValue($sformatf("wdog en c%0d", c), StageEn, 32'h4);
            checkValue("wdog err low", Error, 0);
            tick;
        end
        checkValue("wdog err", Error, 1);
        checkValue("wdog en off", StageEn, 0);
        checkValue("wdog busy", Busy, 0);
        Start = 1'b1;
        tick;
        Start = 1'b0;
        checkValue("wdog start ign err", Error, 1);
        checkValue("wdog start ign en", StageEn, 0);
        Abort = 1'b1;
        tick;
        Abort = 1'b0;
        checkValue("wdog abort err", Error, 0);
        checkValue("wdog abort done", Done, 0);
        tick;
        checkValue("wdog idle busy", Busy, 0);

        // Watchdog: ready on the 5th cycle wins over the limit.
        Start = 1'b1;
        tick;
        Start = 1'b0;
        tick;
        tick;
        for (int c = 0; c < 5; c++) begin
            checkValue($sformatf("wdog2 en c%0d", c), StageEn, 32'h4);
            if (c == 4) StageRy = 6'h3F;
            tick;
        end
        checkValue("wdog2 cur", CurStage, 3);
        checkValue("wdog2 err", Error, 0);
        tick;
        tick;
        tick;
        checkValue("wdog2 done", Done, 1);
        checkValue("wdog2 runcycles", RunCycles, expCyc(10));
        TimeoutLimit = '0;
        StageRy = '0;
        tick;

        // Abort during stage 3.
        StageRy = 6'b000111;
        Start = 1'b1;
        tick;
        Start = 1'b0;
        tick;
        tick;
        tick;
        checkValue("abort cur3", CurStage, 3);
        Abort = 1'b1;
        tick;
        Abort = 1'b0;
        checkValue("abort en", StageEn, 0);
        checkValue("abort busy", Busy, 0);
        checkValue("abort done", Done, 0);
        checkValue("abort cyc held", RunCycles, expCyc(10));
        tick;
        checkValue("abort no done", Done, 0);

        // Abort and Start together in IDLE.
        StageRy = '0;
        Start = 1'b1;
        Abort = 1'b1;
        tick;
        Start = 1'b0;
        Abort = 1'b0;
        checkValue("abortstart busy", Busy, 0);
        checkValue("abortstart en", StageEn, 0);

        // Reset mid-run drops outputs asynchronously.
        Start = 1'b1;
        tick;
        Start = 1'b0;
        checkValue("rstmid en pre", StageEn, 1);
        #1 Rst = 1'b1;
        #1;
        checkValue("rstmid en", StageEn, 0);
        checkValue("rstmid busy", Busy, 0);
        checkValue("rstmid cyc", RunCycles, 0);
        #1 Rst = 1'b0;
        tick;
        checkValue("rstmid idle", Busy, 0);
        checkValue("rstmid no done", Done, 0);

        // All stages skipped.
        SkipMask = 6'h3F;
        Start = 1'b1;
        tick;
        Start = 1'b0;
        SkipMask = '0;
        checkValue("allskip done", Done, 1);
        checkValue("allskip en", StageEn, 0);
        checkValue("allskip busy", Busy, 0);
        checkValue("allskip cyc", RunCycles, 0);
        tick;
        checkValue("allskip done end", Done, 0);

        // Auto-restart DUT: mask held across restart, late mask change ignored.
        SkipAr = 6'b001100;
        RyAr = 6'h3F;
        StartAr = 1'b1;
        tick;
        StartAr = 1'b0;
        SkipAr = '0;
        for (int i = 0; i < 4; i++) begin
            checkValue($sformatf("ar en p1 %0d", i), EnAr, 32'(1 << seqAr[i]));
            tick;
        end
        checkValue("ar done", DoneAr, 1);
        checkValue("ar done en", EnAr, 0);
        checkValue("ar runcycles", RunCycAr, expCyc(4));
        tick;
        for (int i = 0; i < 3; i++) begin
            checkValue($sformatf("ar en p2 %0d", i), EnAr, 32'(1 << seqAr[i]));
            checkValue("ar p2 done", DoneAr, 0);
            tick;
        end
        AbortAr = 1'b1;
        tick;
        AbortAr = 1'b0;
        checkValue("ar abort busy", BusyAr, 0);
        tick;
        checkValue("ar stays idle", BusyAr, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
        $finish;
    end

endmodule
`default_nettype wire
